// File: rtl/hps_pio_pkg.sv
// Shared constants for the HPS PIO bank: register offsets, edge-type encodings
// and the address-width helper.
package hps_pio_pkg;

  localparam logic [2:0] REG_DATA      = 3'd0;
  localparam logic [2:0] REG_DIRECTION = 3'd1;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd2;
  localparam logic [2:0] REG_EDGE_CAP  = 3'd3;
  localparam logic [2:0] REG_OUTSET    = 3'd4;
  localparam logic [2:0] REG_OUTCLEAR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int pio_addr_width(input int channels);
    return $clog2(channels) + 3;
  endfunction

endpackage

// File: rtl/hps_pio_sync.sv
// WIDTH-bit, SYNC_STAGES-deep input synchroniser; with PIO_EDGE_IRQ_EN defined
// it also provides a per-bit edge strobe selected by EDGE_TYPE.
module hps_pio_sync
  import hps_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
`ifdef PIO_EDGE_IRQ_EN
  ,
  output logic [WIDTH-1:0] edge_o
`endif
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  // Synchroniser shift chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < SYNC_STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] dly_q;

  // One-cycle delayed copy of the synchronised value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dly_q <= '0;
    else          dly_q <= q_o;
  end

  // Edge selection
  always_comb begin
    edge_o = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_o = q_o & ~dly_q;
      EDGE_FALL: edge_o = ~q_o & dly_q;
      EDGE_ANY:  edge_o = q_o ^ dly_q;
      default:   edge_o = q_o & ~dly_q;
    endcase
  end
`endif

endmodule

// File: rtl/hps_pio_bank.sv
// Multi-channel Avalon-MM PIO bank with direction control and atomic set/clear.
// Edge capture, IRQ mask and irq exist only when PIO_EDGE_IRQ_EN is defined.
module hps_pio_bank
  import hps_pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          CHANNELS    = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  localparam int         AW          = pio_addr_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AW-1:0]             address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic [CHANNELS*WIDTH-1:0] oe,
  output logic                      irq
);

  localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0] out_q  [CHANNELS];
  logic [WIDTH-1:0] out_d  [CHANNELS];
  logic [WIDTH-1:0] dir_q  [CHANNELS];
  logic [WIDTH-1:0] dir_d  [CHANNELS];
  logic [WIDTH-1:0] sync_s [CHANNELS];

  logic             we_s;
  logic [2:0]       reg_s;
  logic [31:0]      ch_s;
  logic             ch_ok_s;
  logic [CIW-1:0]   ch_idx_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] rd_s;

  assign we_s     = chipselect & ~write_n;
  assign reg_s    = address[2:0];
  assign ch_s     = 32'(address) >> 3;
  assign ch_ok_s  = (ch_s < 32'(CHANNELS));
  assign ch_idx_s = ch_s[CIW-1:0];
  assign wd_s     = writedata[WIDTH-1:0];

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_s [CHANNELS];
  logic [WIDTH-1:0] mask_q [CHANNELS];
  logic [WIDTH-1:0] mask_d [CHANNELS];
  logic [WIDTH-1:0] cap_q  [CHANNELS];
  logic [WIDTH-1:0] cap_d  [CHANNELS];
  logic             irq_d;
  logic             irq_q;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    hps_pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (in_port[c*WIDTH +: WIDTH]),
      .q_o     (sync_s[c])
`ifdef PIO_EDGE_IRQ_EN
      ,
      .edge_o  (edge_s[c])
`endif
    );
    assign out_port[c*WIDTH +: WIDTH] = out_q[c];
    assign oe[c*WIDTH +: WIDTH]       = dir_q[c];
  end

  // Next state of DATA_OUT and DIRECTION from bus writes
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      out_d[c] = out_q[c];
      dir_d[c] = dir_q[c];
      if (we_s && (ch_s == 32'(c))) begin
        case (reg_s)
          REG_DATA:      out_d[c] = wd_s;
          REG_DIRECTION: dir_d[c] = wd_s;
          REG_OUTSET:    out_d[c] = out_q[c] | wd_s;
          REG_OUTCLEAR:  out_d[c] = out_q[c] & ~wd_s;
          default:       out_d[c] = out_q[c];
        endcase
      end else begin
        out_d[c] = out_q[c];
      end
    end
  end

  // DATA_OUT and DIRECTION registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        out_q[c] <= RESET_VALUE[WIDTH-1:0];
        dir_q[c] <= '0;
      end
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

`ifdef PIO_EDGE_IRQ_EN
  // Mask writes and edge capture; a new edge overrides a same-cycle W1C
  always_comb begin
    irq_d = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      mask_d[c] = mask_q[c];
      cap_d[c]  = cap_q[c] | edge_s[c];
      if (we_s && (ch_s == 32'(c))) begin
        case (reg_s)
          REG_IRQ_MASK: mask_d[c] = wd_s;
          REG_EDGE_CAP: cap_d[c]  = (cap_q[c] & ~wd_s) | edge_s[c];
          default:      mask_d[c] = mask_q[c];
        endcase
      end else begin
        mask_d[c] = mask_q[c];
      end
      irq_d = irq_d | (|(cap_q[c] & mask_q[c]));
    end
  end

  // IRQ mask, edge capture and irq registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        mask_q[c] <= '0;
        cap_q[c]  <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Zero-wait-state read mux
  always_comb begin
    rd_s = '0;
    if (ch_ok_s) begin
      case (reg_s)
        REG_DATA:      rd_s = (sync_s[ch_idx_s] & ~dir_q[ch_idx_s]) |
                              (out_q[ch_idx_s] & dir_q[ch_idx_s]);
        REG_DIRECTION: rd_s = dir_q[ch_idx_s];
`ifdef PIO_EDGE_IRQ_EN
        REG_IRQ_MASK:  rd_s = mask_q[ch_idx_s];
        REG_EDGE_CAP:  rd_s = cap_q[ch_idx_s];
`endif
        default:       rd_s = '0;
      endcase
    end else begin
      rd_s = '0;
    end
  end

  assign readdata = 32'(rd_s);

endmodule

// File: tb/tb_hps_pio_bank.sv
// Directed self-checking bench for hps_pio_bank (3 channels, RESET_VALUE 0x5A);
// the edge/irq sequences build only when PIO_EDGE_IRQ_EN is defined.
module tb_hps_pio_bank;
  import hps_pio_pkg::*;

  localparam int CH = 3;
  localparam int W  = 32;
  localparam int AW = pio_addr_width(CH);
`ifdef PIO_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [CH*W-1:0]   in_port;
  logic [CH*W-1:0]   out_port;
  logic [CH*W-1:0]   oe;
  logic              irq;

  int checks = 0;
  int failures = 0;

  hps_pio_bank #(
    .WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(2), .EDGE_TYPE(0),
    .RESET_VALUE(32'h0000_005A)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wch;
    logic [2:0]  wreg;
    logic [31:0] wdata;
    int          rch;
    logic [2:0]  rreg;
    logic [31:0] exp_rd;
    logic [31:0] exp_ch1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input int ch, input logic [2:0] rg, input logic [31:0] data);
    @(negedge clk);
    address    = AW'({ch[AW-4:0], rg});
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input logic [2:0] rg, output logic [31:0] data);
    @(negedge clk);
    address    = AW'({ch[AW-4:0], rg});
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    data = readdata;
  endtask

  task automatic set_addr(input int ch, input logic [2:0] rg);
    address = AW'({ch[AW-4:0], rg});
  endtask

  logic [31:0] rd;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = '0;

    //            wch wreg           wdata          rch rreg           exp_rd         exp_ch1
    vecs[0]  = '{1, REG_DATA,      32'hF0F0_0000, 1, REG_DATA,      32'h0000_0000, 32'hF0F0_0000};
    vecs[1]  = '{1, REG_DIRECTION, 32'hFFFF_FFFF, 1, REG_DATA,      32'hF0F0_0000, 32'hF0F0_0000};
    vecs[2]  = '{1, REG_OUTSET,    32'h0000_000F, 1, REG_DATA,      32'hF0F0_000F, 32'hF0F0_000F};
    vecs[3]  = '{1, REG_OUTCLEAR,  32'hF000_0000, 1, REG_DATA,      32'h00F0_000F, 32'h00F0_000F};
    vecs[4]  = '{1, REG_OUTSET,    32'h1234_5678, 1, REG_OUTSET,    32'h0000_0000, 32'h12F4_567F};
    vecs[5]  = '{1, REG_DIRECTION, 32'hFFFF_0000, 1, REG_DATA,      32'h12F4_0000, 32'h12F4_567F};
    vecs[6]  = '{0, REG_DIRECTION, 32'h0000_00FF, 0, REG_DATA,      32'h0000_005A, 32'h12F4_567F};
    vecs[7]  = '{3, REG_DATA,      32'hDEAD_BEEF, 3, REG_DATA,      32'h0000_0000, 32'h12F4_567F};
    vecs[8]  = '{1, 3'd7,          32'hFFFF_FFFF, 1, 3'd7,          32'h0000_0000, 32'h12F4_567F};
    vecs[9]  = '{3, REG_DIRECTION, 32'hFFFF_FFFF, 1, REG_DIRECTION, 32'hFFFF_0000, 32'h12F4_567F};
    vecs[10] = '{0, REG_OUTCLEAR,  32'h0000_000F, 0, REG_DATA,      32'h0000_0050, 32'h12F4_567F};
    vecs[11] = '{2, REG_IRQ_MASK,  32'h0000_0005, 2, REG_IRQ_MASK,
                 EDGE_EN ? 32'h0000_0005 : 32'h0000_0000, 32'h12F4_567F};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_out_port", out_port, {3{32'h0000_005A}});
    check("reset_oe", oe, '0);
    check("reset_irq", {95'd0, irq}, '0);
    bus_read(0, REG_DATA, rd);
    check("reset_data_read", {64'd0, rd}, '0);

    for (int i = 0; i < 12; i++) begin
      bus_write(vecs[i].wch, vecs[i].wreg, vecs[i].wdata);
      bus_read(vecs[i].rch, vecs[i].rreg, rd);
      check($sformatf("vec%0d_readdata", i), {64'd0, rd}, {64'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_out_ch1", i), {64'd0, out_port[W +: W]}, {64'd0, vecs[i].exp_ch1});
    end
    check("oe_all", oe, {32'h0000_0000, 32'hFFFF_0000, 32'h0000_00FF});
    check("out_ch2_untouched", {64'd0, out_port[2*W +: W]}, {64'd0, 32'h0000_005A});
    bus_read(1, 3'd6, rd);
    check("reg6_read", {64'd0, rd}, '0);

    // DATA read latency through the synchroniser, ch2 bit 3 rising
    @(negedge clk);
    set_addr(2, REG_DATA);
    in_port[2*W +: W] = 32'h0000_0008;
    @(negedge clk); #1;
    check("sync_lat_1", {64'd0, readdata}, '0);
    @(negedge clk); #1;
    check("sync_lat_2", {64'd0, readdata}, {64'd0, 32'h0000_0008});

`ifdef PIO_EDGE_IRQ_EN
    set_addr(2, REG_EDGE_CAP); #1;
    check("cap_before", {64'd0, readdata}, '0);
    @(negedge clk); #1;
    check("cap_after_3", {64'd0, readdata}, {64'd0, 32'h0000_0008});
    check("irq_masked_off", {95'd0, irq}, '0);
    @(negedge clk);
    check("irq_still_off", {95'd0, irq}, '0);
    bus_write(2, REG_IRQ_MASK, 32'h0000_0008);
    check("irq_write_cycle", {95'd0, irq}, '0);
    @(posedge clk); #1;
    check("irq_after_mask", {95'd0, irq}, 96'd1);

    // W1C without an edge: capture clears now, irq drops one cycle later
    bus_write(2, REG_EDGE_CAP, 32'h0000_0008);
    check("irq_clear_cycle", {95'd0, irq}, 96'd1);
    @(posedge clk); #1;
    check("irq_dropped", {95'd0, irq}, '0);
    bus_read(2, REG_EDGE_CAP, rd);
    check("cap_cleared", {64'd0, rd}, '0);

    // Falling edge must not capture with EDGE_TYPE rising
    in_port[2*W +: W] = 32'h0000_0000;
    repeat (5) @(negedge clk);
    #1;
    check("no_fall_capture", {64'd0, readdata}, '0);

    // Re-arm capture, then W1C on the very cycle a new rising edge is captured
    in_port[2*W +: W] = 32'h0000_0008;
    repeat (4) @(negedge clk);
    check("rearm_irq", {95'd0, irq}, 96'd1);
    in_port[2*W +: W] = 32'h0000_0000;
    repeat (4) @(negedge clk);
    in_port[2*W +: W] = 32'h0000_0008;
    @(negedge clk);
    bus_write(2, REG_EDGE_CAP, 32'h0000_0008);
    bus_read(2, REG_EDGE_CAP, rd);
    check("collision_cap", {64'd0, rd}, {64'd0, 32'h0000_0008});
    check("collision_irq", {95'd0, irq}, 96'd1);
    @(negedge clk);
    check("collision_irq_next", {95'd0, irq}, 96'd1);

    // Mid-operation reset clears everything and leaves no pending irq
    in_port = '0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_irq", {95'd0, irq}, '0);
    check("midrst_out", out_port, {3{32'h0000_005A}});
    check("midrst_oe", oe, '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_irq", {95'd0, irq}, '0);
    bus_read(2, REG_EDGE_CAP, rd);
    check("postrst_cap", {64'd0, rd}, '0);
    bus_read(2, REG_IRQ_MASK, rd);
    check("postrst_mask", {64'd0, rd}, '0);
`else
    bus_write(2, REG_IRQ_MASK, 32'hFFFF_FFFF);
    bus_write(2, REG_EDGE_CAP, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_port = {3{(i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000}};
      repeat (3) @(negedge clk);
      check($sformatf("dis_irq_%0d", i), {95'd0, irq}, '0);
    end
    bus_read(2, REG_IRQ_MASK, rd);
    check("dis_mask_read", {64'd0, rd}, '0);
    bus_read(2, REG_EDGE_CAP, rd);
    check("dis_cap_read", {64'd0, rd}, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
